// File: rtl/stream_interface_ctrl.sv
// rtl/stream_interface_ctrl.sv - multi-word burst host handshake sequencer with abort path
// Optional watchdog timeout and sticky I_ERROR state: define STREAM_IF_TIMEOUT_EN.
module stream_interface_ctrl #(
  parameter int WORDS_PER_REQ  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IDX_W          = (WORDS_PER_REQ > 1) ? $clog2(WORDS_PER_REQ) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             input_request,
  input  logic             input_valid,
  input  logic             output_is_ready,
  input  logic             output_acknowledge,
  input  logic             abort,
  output logic             core_load,
  output logic [2:0]       state_out,
  output logic [IDX_W-1:0] word_index,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    I_IDLE       = 3'd0,
    I_LOAD       = 3'd1,
    I_PROCESSING = 3'd2,
    I_DONE       = 3'd3,
    I_ERROR      = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_REQ - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;

`ifdef STREAM_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             active;

  assign active  = (state == I_LOAD) || (state == I_PROCESSING) || (state == I_DONE);
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in the current active state; restarts on every transition.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      cnt <= '0;
    else if ((state_d != state) || !active)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      I_IDLE: begin
        if (input_request) begin
          state_d = I_LOAD;
          idx_d   = '0;
        end
      end
      I_LOAD: begin
        if (input_valid)
          state_d = I_PROCESSING;
`ifdef STREAM_IF_TIMEOUT_EN
        else if (timeout)
          state_d = I_ERROR;
`endif
      end
      I_PROCESSING: begin
        if (output_is_ready)
          state_d = I_DONE;
`ifdef STREAM_IF_TIMEOUT_EN
        else if (timeout)
          state_d = I_ERROR;
`endif
      end
      I_DONE: begin
        if (output_acknowledge) begin
          if (idx == LAST_IDX) begin
            state_d = I_IDLE;
            idx_d   = '0;
          end else begin
            state_d = I_LOAD;
            idx_d   = idx + 1'b1;
          end
        end
`ifdef STREAM_IF_TIMEOUT_EN
        else if (timeout)
          state_d = I_ERROR;
`endif
      end
`ifdef STREAM_IF_TIMEOUT_EN
      // Sticky: word index is kept for debug until the host aborts.
      I_ERROR: state_d = I_ERROR;
`endif
      default: begin
        state_d = I_IDLE;
        idx_d   = '0;
      end
    endcase
    if (abort && (state != I_IDLE)) begin
      state_d = I_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= I_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  assign state_out  = state;
  assign word_index = idx;
  assign busy       = (state != I_IDLE);
  assign core_load  = (state == I_LOAD) && input_valid;
`ifdef STREAM_IF_TIMEOUT_EN
  assign error      = (state == I_ERROR);
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_stream_interface_ctrl.sv
// tb/tb_stream_interface_ctrl.sv - scoreboard bench for stream_interface_ctrl
// Timeout scenarios run when STREAM_IF_TIMEOUT_EN is defined.
module tb_stream_interface_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       input_request, input_valid, output_is_ready, output_acknowledge, abort;
  logic       core_load, busy, error;
  logic [2:0] state_out;
  logic [1:0] word_index;
  logic       core_load1, busy1, error1;
  logic [2:0] state_out1;
  logic [0:0] word_index1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] idx;
    logic       bsy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  stream_interface_ctrl #(.WORDS_PER_REQ(4), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .nrst(nrst), .input_request(input_request), .input_valid(input_valid),
    .output_is_ready(output_is_ready), .output_acknowledge(output_acknowledge), .abort(abort),
    .core_load(core_load), .state_out(state_out), .word_index(word_index),
    .busy(busy), .error(error)
  );

  stream_interface_ctrl #(.WORDS_PER_REQ(1), .TIMEOUT_CYCLES(8)) u_one (
    .clk(clk), .nrst(nrst), .input_request(input_request), .input_valid(input_valid),
    .output_is_ready(output_is_ready), .output_acknowledge(output_acknowledge), .abort(abort),
    .core_load(core_load1), .state_out(state_out1), .word_index(word_index1),
    .busy(busy1), .error(error1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    input_request      = 1'b0;
    input_valid        = 1'b0;
    output_is_ready    = 1'b0;
    output_acknowledge = 1'b0;
    abort              = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    #3;
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    total++; if (word_index !== 2'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", word_index); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (core_load !== 1'b0) begin bad++; $display("FAIL reset_core_load got=%b exp=0", core_load); end
    total++; if (state_out1 !== 3'd0) begin bad++; $display("FAIL reset_state1 got=%0d exp=0", state_out1); end
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_burst();
    logic [2:0] st_tab [13] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3,
                                3'd1, 3'd2, 3'd3, 3'd0};
    exp_t e;
    int   pulses = 0;
    do_reset();
    input_request = 1'b1; input_valid = 1'b1; output_is_ready = 1'b1; output_acknowledge = 1'b1;
    for (int i = 0; i < 13; i++)
      sb.push_back(exp_t'{st: st_tab[i], idx: (i == 12) ? 2'd0 : 2'(i / 3), bsy: (i != 12)});
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) input_request = 1'b0;
      e = sb.pop_front();
      total++; if (state_out !== e.st) begin bad++; $display("FAIL burst_state[%0d] got=%0d exp=%0d", i, state_out, e.st); end
      total++; if (word_index !== e.idx) begin bad++; $display("FAIL burst_index[%0d] got=%0d exp=%0d", i, word_index, e.idx); end
      total++; if (busy !== e.bsy) begin bad++; $display("FAIL burst_busy[%0d] got=%b exp=%b", i, busy, e.bsy); end
      total++; if (core_load !== (e.st == 3'd1)) begin bad++; $display("FAIL burst_core_load[%0d] got=%b exp=%b", i, core_load, e.st == 3'd1); end
      if (core_load === 1'b1) pulses++;
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL burst_pulses got=%0d exp=4", pulses); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [2:0] st_tab [13] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3,
                                3'd1, 3'd2, 3'd3, 3'd0};
    exp_t e;
    do_reset();
    input_request = 1'b1; input_valid = 1'b1; output_is_ready = 1'b1; output_acknowledge = 1'b1;
    for (int i = 0; i < 26; i++)
      sb.push_back(exp_t'{st: st_tab[i % 13], idx: ((i % 13) == 12) ? 2'd0 : 2'((i % 13) / 3),
                          bsy: ((i % 13) != 12)});
    for (int i = 0; i < 26; i++) begin
      tick();
      if (i == 13) input_request = 1'b0;
      e = sb.pop_front();
      total++; if (state_out !== e.st || word_index !== e.idx) begin
        bad++; $display("FAIL b2b[%0d] got=%0d/%0d exp=%0d/%0d", i, state_out, word_index, e.st, e.idx);
      end
    end
    idle_inputs();
  endtask

  task automatic test_single_word_stall();
    exp_t e;
    do_reset();
    sb.push_back(exp_t'{st: 3'd1, idx: 2'd0, bsy: 1'b1});
    sb.push_back(exp_t'{st: 3'd2, idx: 2'd0, bsy: 1'b1});
    for (int i = 0; i < 5; i++) sb.push_back(exp_t'{st: 3'd2, idx: 2'd0, bsy: 1'b1});
    sb.push_back(exp_t'{st: 3'd3, idx: 2'd0, bsy: 1'b1});
    sb.push_back(exp_t'{st: 3'd0, idx: 2'd0, bsy: 1'b0});
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      case (i)
        0:       input_request = 1'b1;
        1:       input_valid = 1'b1;
        7:       output_is_ready = 1'b1;
        8:       output_acknowledge = 1'b1;
        default: ;
      endcase
      tick();
      e = sb.pop_front();
      total++; if (state_out1 !== e.st) begin bad++; $display("FAIL single_state[%0d] got=%0d exp=%0d", i, state_out1, e.st); end
      total++; if (busy1 !== e.bsy) begin bad++; $display("FAIL single_busy[%0d] got=%b exp=%b", i, busy1, e.bsy); end
      total++; if (word_index1 !== e.idx[0]) begin bad++; $display("FAIL single_index[%0d] got=%0d exp=%0d", i, word_index1, e.idx); end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    input_request = 1'b1; input_valid = 1'b1; output_is_ready = 1'b1; output_acknowledge = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      input_request = 1'b0;
    end
    total++; if (state_out !== 3'd3 || word_index !== 2'd2) begin
      bad++; $display("FAIL abort_setup got=%0d/%0d exp=3/2", state_out, word_index);
    end
    abort = 1'b1;
    tick();
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", state_out); end
    total++; if (word_index !== 2'd0) begin bad++; $display("FAIL abort_index got=%0d exp=0", word_index); end
    idle_inputs();
    abort = 1'b1;
    tick();
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", state_out); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    input_request = 1'b1; input_valid = 1'b1; output_is_ready = 1'b1; output_acknowledge = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      input_request = 1'b0;
    end
    total++; if (state_out !== 3'd1 || word_index !== 2'd1) begin
      bad++; $display("FAIL nrst_setup got=%0d/%0d exp=1/1", state_out, word_index);
    end
    #2;
    nrst = 1'b0;
    #1;
    total++; if (state_out !== 3'd0 || word_index !== 2'd0) begin
      bad++; $display("FAIL nrst_async got=%0d/%0d exp=0/0", state_out, word_index);
    end
    total++; if (busy !== 1'b0 || core_load !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL nrst_outputs got=%b%b%b exp=000", busy, core_load, error);
    end
    idle_inputs();
    tick();
    nrst = 1'b1;
    input_request = 1'b1;
    tick();
    total++; if (state_out !== 3'd1 || word_index !== 2'd0) begin
      bad++; $display("FAIL nrst_restart got=%0d/%0d exp=1/0", state_out, word_index);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    input_request = 1'b1; input_valid = 1'b1; output_is_ready = 1'b1; output_acknowledge = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      input_request = 1'b0;
    end
    output_is_ready = 1'b0; output_acknowledge = 1'b0;
    tick();
    input_valid = 1'b0;
    total++; if (state_out !== 3'd2) begin bad++; $display("FAIL timeout_enter got=%0d exp=2", state_out); end
`ifdef STREAM_IF_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      total++; if (state_out !== 3'd2) begin bad++; $display("FAIL timeout_hold[%0d] got=%0d exp=2", k, state_out); end
    end
    tick();
    total++; if (state_out !== 3'd4 || error !== 1'b1) begin
      bad++; $display("FAIL timeout_error got=%0d/%b exp=4/1", state_out, error);
    end
    total++; if (word_index !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_index got=%0d/%b exp=1/1", word_index, busy);
    end
    output_is_ready = 1'b1; output_acknowledge = 1'b1; input_request = 1'b1;
    tick();
    total++; if (state_out !== 3'd4) begin bad++; $display("FAIL error_sticky got=%0d exp=4", state_out); end
    idle_inputs();
    abort = 1'b1;
    tick();
    total++; if (state_out !== 3'd0 || error !== 1'b0 || word_index !== 2'd0) begin
      bad++; $display("FAIL error_abort got=%0d/%b/%0d exp=0/0/0", state_out, error, word_index);
    end
    do_reset();
    input_request = 1'b1;
    tick();
    idle_inputs();
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    output_is_ready = 1'b1;
    tick();
    total++; if (state_out !== 3'd3 || error !== 1'b0) begin
      bad++; $display("FAIL timeout_late_exit got=%0d/%b exp=3/0", state_out, error);
    end
`else
    for (int k = 0; k < 10; k++) tick();
    total++; if (state_out !== 3'd2 || error !== 1'b0) begin
      bad++; $display("FAIL no_timeout got=%0d/%b exp=2/0", state_out, error);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    nrst = 1'b0;
    idle_inputs();
    test_reset();
    test_burst();
    test_back_to_back();
    test_single_word_stall();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
